// File: rtl/id_ex_stage_pkg.sv
// Shared opcode constants, default widths and the ID/EX control bundle for the decode stage.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } idex_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode decode: memory/regfile controls, rt usage and destination select.
module id_decode
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    output idex_ctrl_t ctrl_o,
    output logic       uses_rt_o,
    output logic       dest_rd_o
);

    always_comb begin
        ctrl_o    = '0;
        uses_rt_o = 1'b0;
        dest_rd_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                uses_rt_o        = 1'b1;
                dest_rd_o        = 1'b1;
            end
            OP_LW: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: ctrl_o.reg_write = 1'b1;
            OP_BEQ, OP_BNE:           uses_rt_o        = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX register with load-use bubble; priority reset > flush > ex_hold > hazard.
// Defining ID_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc_plus4,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_out,
    output logic [REG_AW-1:0] read1,
    output logic [REG_AW-1:0] read2,
    input  logic [DATA_W-1:0] register1,
    input  logic [DATA_W-1:0] register2,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_write,
    input  logic [DATA_W-1:0] wb_writeData,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [31:0]       ex_pc_plus4,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_RegWrite
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    idex_ctrl_t        dec_ctrl;
    logic              uses_rt;
    logic              dest_rd;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              hazard;

    logic              valid_q, valid_d;
    idex_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;
    logic [31:0]       pc_q, pc_d;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign read1  = rs;
    assign read2  = rt;

    id_decode u_decode (
        .opcode_i  (opcode),
        .ctrl_o    (dec_ctrl),
        .uses_rt_o (uses_rt),
        .dest_rd_o (dest_rd)
    );

`ifdef ID_WB_BYPASS_EN
    logic byp_rs, byp_rt;
    assign byp_rs = wb_RegWrite && (wb_write != '0) && (wb_write == rs);
    assign byp_rt = wb_RegWrite && (wb_write != '0) && (wb_write == rt);
    assign rs_val = (rs == '0) ? '0 : (byp_rs ? wb_writeData : register1);
    assign rt_val = (rt == '0) ? '0 : (byp_rt ? wb_writeData : register2);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_RegWrite, wb_write, wb_writeData};
    assign rs_val = (rs == '0) ? '0 : register1;
    assign rt_val = (rt == '0) ? '0 : register2;
`endif

    // A load in EX whose result the decoding instruction needs must wait one cycle.
    assign hazard = instr_valid && valid_q && ctrl_q.mem_read && (dest_q != '0) &&
                    ((dest_q == rs) || (uses_rt && (dest_q == rt)));

    assign stall_out = !flush && (ex_hold || hazard);

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dest_d    = dest_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        pc_d      = pc_q;
        if (flush || (!ex_hold && hazard)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!ex_hold) begin
            valid_d   = instr_valid;
            ctrl_d    = instr_valid ? dec_ctrl : '0;
            rs_data_d = rs_val;
            rt_data_d = rt_val;
            imm_d     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
            rs_d      = rs;
            rt_d      = rt;
            dest_d    = dest_rd ? rd : rt;
            opcode_d  = opcode;
            funct_d   = instr[5:0];
            pc_d      = pc_plus4;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            opcode_q  <= '0;
            funct_q   <= '0;
            pc_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            pc_q      <= pc_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dest     = dest_q;
    assign ex_opcode   = opcode_q;
    assign ex_funct    = funct_q;
    assign ex_pc_plus4 = pc_q;

endmodule
